// File: rtl/ac_cmd_encoder.sv
// ac_cmd_encoder: debounced air-conditioner keypad to IR frame words with hold-off between frames
module ac_cmd_encoder #(
    parameter int T_TICK     = 125000,
    parameter int DEB_TICKS  = 10,
    parameter int HOLD_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_power,
    input  logic        key_mode,
    input  logic        key_fan,
    input  logic        key_up,
    input  logic        key_down,
    output logic [34:0] IR_in_data35,
    output logic [32:0] IR_in_data32,
    output logic        frame_stb,
    output logic [4:0]  temp_disp
);
    localparam int TW = $clog2(T_TICK + 1);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [4:0]     keys, sync1, sync2, deb, deb_prev, rise;
    logic [DW-1:0]  deb_cnt [5];
    logic           power, chg, tgl, pending, publish, hold_end;
    logic [2:0]     mode;
    logic [4:0]     temp;
    logic [1:0]     fan;
    logic [3:0]     temp_code, chk;
    logic [HW-1:0]  hold_cnt;

    // key order is {power, mode, fan, up, down}, highest priority in the MSB
    assign keys      = {key_power, key_mode, key_fan, key_up, key_down};
    assign tick      = tick_cnt == TW'(T_TICK - 1);
    assign rise      = deb & ~deb_prev;
    assign temp_code = 4'(temp - 5'd16);
    assign chk       = {1'b0, mode} + temp_code + 4'd5 + {3'b000, power};
    assign temp_disp = temp;

    // free-running tick divider
    always_ff @(posedge clk or negedge rst)
        if (!rst) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    // two-flop synchronisers and edge-detect history of the debounced levels
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb_prev <= '0;
        end else begin
            sync1    <= keys;
            sync2    <= sync1;
            deb_prev <= deb;
        end

    // a new level is accepted after DEB_TICKS consecutive tick samples that differ from the current one
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 5; i++)
                if (sync2[i] == deb[i]) deb_cnt[i] <= '0;
                else if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end

    // settings: one event per cycle by priority; only power is honoured while off
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            power <= 1'b0;
            mode  <= 3'd1;
            temp  <= 5'd26;
            fan   <= 2'd0;
            chg   <= 1'b0;
        end else begin
            chg <= rise[4] | (power & |rise[3:0]);
            if (rise[4]) power <= ~power;
            else if (power) begin
                if (rise[3]) mode <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
                else if (rise[2]) fan <= fan + 2'd1;
                else if (rise[1]) temp <= (temp == 5'd30) ? temp : temp + 5'd1;
                else if (rise[0]) temp <= (temp == 5'd16) ? temp : temp - 5'd1;
            end
        end

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    // publish decision and next state; a change arriving on the expiry tick is published then
    always_comb begin
        hold_end = (state == HOLD) && tick && (hold_cnt == HW'(HOLD_TICKS - 1));
        publish  = (state == IDLE) ? chg : hold_end && (pending || chg);
        state_nx = state;
        if (state == IDLE && chg) state_nx = HOLD;
        else if (hold_end && !(pending || chg)) state_nx = IDLE;
    end

    // hold counter, pending flag and the published words; tgl flips so each frame differs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hold_cnt     <= '0;
            pending      <= 1'b0;
            tgl          <= 1'b0;
            frame_stb    <= 1'b0;
            IR_in_data35 <= '0;
            IR_in_data32 <= '0;
        end else begin
            frame_stb <= publish;
            if (publish) begin
                hold_cnt     <= '0;
                pending      <= 1'b0;
                tgl          <= ~tgl;
                IR_in_data35 <= {mode, power, fan, temp_code, 22'h040100, 3'b010};
                IR_in_data32 <= {~tgl, chk, 28'h0002000};
            end else begin
                if (state == HOLD && tick) hold_cnt <= hold_cnt + 1'b1;
                if (state == HOLD && chg) pending <= 1'b1;
            end
        end
endmodule

// File: tb/tb_ac_cmd_encoder.sv
// tb_ac_cmd_encoder: table-driven key vectors plus directed hold/reset sequences
module tb_ac_cmd_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  kb = '0;
    logic [34:0] d35;
    logic [32:0] d32;
    logic        frame_stb;
    logic [4:0]  temp_disp;
    int          frames = 0;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [4:0]  keys;
        logic [4:0]  temp;
        int          nfr;
        logic [34:0] d35;
        logic [32:0] d32;
    } vec_t;
    vec_t tbl [19];

    ac_cmd_encoder #(.T_TICK(10), .DEB_TICKS(3), .HOLD_TICKS(5)) dut (
        .clk(clk), .rst(rst),
        .key_power(kb[4]), .key_mode(kb[3]), .key_fan(kb[2]), .key_up(kb[1]), .key_down(kb[0]),
        .IR_in_data35(d35), .IR_in_data32(d32), .frame_stb(frame_stb), .temp_disp(temp_disp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_stb) frames++;
    end

    function automatic logic [34:0] w35(input int m, input int p, input int f, input int t);
        return {3'(m), 1'(p), 2'(f), 4'(t - 16), 22'h040100, 3'b010};
    endfunction

    function automatic logic [32:0] w32(input int g, input int c);
        return {1'(g), 4'(c), 28'h0002000};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] k);
        kb = k;
        cyc(50);
        kb = '0;
        cyc(150);
    endtask

    task automatic wait_frame(input int n);
        int b = 0;
        while (frames < n && b < 200) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (frames < n) begin
            fails++;
            $display("FAIL wait_frame: frames %0d required %0d", frames, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        kb  = '0;
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
    endtask

    initial begin
        int f0;
        tbl[0]  = '{5'b01000, 5'd26, 0, 35'd0, 33'd0};
        tbl[1]  = '{5'b10010, 5'd26, 1, w35(1, 1, 0, 26), w32(1, 1)};
        tbl[2]  = '{5'b00010, 5'd27, 1, w35(1, 1, 0, 27), w32(0, 2)};
        tbl[3]  = '{5'b00010, 5'd28, 1, w35(1, 1, 0, 28), w32(1, 3)};
        tbl[4]  = '{5'b00010, 5'd29, 1, w35(1, 1, 0, 29), w32(0, 4)};
        tbl[5]  = '{5'b00010, 5'd30, 1, w35(1, 1, 0, 30), w32(1, 5)};
        tbl[6]  = '{5'b00010, 5'd30, 1, w35(1, 1, 0, 30), w32(0, 5)};
        tbl[7]  = '{5'b00001, 5'd29, 1, w35(1, 1, 0, 29), w32(1, 4)};
        tbl[8]  = '{5'b01000, 5'd29, 1, w35(2, 1, 0, 29), w32(0, 5)};
        tbl[9]  = '{5'b01000, 5'd29, 1, w35(3, 1, 0, 29), w32(1, 6)};
        tbl[10] = '{5'b01000, 5'd29, 1, w35(4, 1, 0, 29), w32(0, 7)};
        tbl[11] = '{5'b01000, 5'd29, 1, w35(0, 1, 0, 29), w32(1, 3)};
        tbl[12] = '{5'b00100, 5'd29, 1, w35(0, 1, 1, 29), w32(0, 3)};
        tbl[13] = '{5'b00100, 5'd29, 1, w35(0, 1, 2, 29), w32(1, 3)};
        tbl[14] = '{5'b00100, 5'd29, 1, w35(0, 1, 3, 29), w32(0, 3)};
        tbl[15] = '{5'b00100, 5'd29, 1, w35(0, 1, 0, 29), w32(1, 3)};
        tbl[16] = '{5'b01110, 5'd29, 1, w35(1, 1, 0, 29), w32(0, 4)};
        tbl[17] = '{5'b10000, 5'd29, 1, w35(1, 0, 0, 29), w32(1, 3)};
        tbl[18] = '{5'b00010, 5'd29, 0, w35(1, 0, 0, 29), w32(1, 3)};

        cyc(3);
        chk("reset_d35", 64'(d35), 64'd0);
        chk("reset_d32", 64'(d32), 64'd0);
        chk("reset_stb", 64'(frame_stb), 64'd0);
        chk("reset_temp", 64'(temp_disp), 64'd26);
        rst = 1'b1;
        cyc(5);

        f0 = frames;
        kb[4] = 1'b1; cyc(7); kb[4] = 1'b0; cyc(1); kb[4] = 1'b1; cyc(7);
        kb[4] = 1'b0; cyc(10);
        kb[4] = 1'b1; cyc(15);
        kb[4] = 1'b0; cyc(100);
        chk("glitch_frames", 64'(frames - f0), 64'd0);
        chk("glitch_d35", 64'(d35), 64'd0);

        for (int i = 0; i < 19; i++) begin
            f0 = frames;
            press(tbl[i].keys);
            chk($sformatf("v%0d_temp", i), 64'(temp_disp), 64'(tbl[i].temp));
            chk($sformatf("v%0d_frames", i), 64'(frames - f0), 64'(tbl[i].nfr));
            chk($sformatf("v%0d_d35", i), 64'(d35), 64'(tbl[i].d35));
            chk($sformatf("v%0d_d32", i), 64'(d32), 64'(tbl[i].d32));
        end

        f0 = frames;
        press(5'b10000);
        for (int i = 0; i < 14; i++) press(5'b00001);
        chk("down_sat_temp", 64'(temp_disp), 64'd16);
        chk("down_sat_frames", 64'(frames - f0), 64'd15);
        chk("down_sat_d35", 64'(d35), 64'(w35(1, 1, 0, 16)));
        chk("down_sat_d32", 64'(d32), 64'(w32(0, 7)));

        do_reset();
        f0 = frames;
        kb[4] = 1'b1; cyc(10);
        kb[3] = 1'b1; cyc(10);
        kb[2] = 1'b1; cyc(10);
        kb[1] = 1'b1;
        wait_frame(f0 + 1);
        cyc(15);
        chk("hold_mid_frames", 64'(frames - f0), 64'd1);
        chk("hold_mid_d35", 64'(d35), 64'(w35(1, 1, 0, 26)));
        cyc(80);
        chk("hold_end_frames", 64'(frames - f0), 64'd2);
        chk("hold_end_d35", 64'(d35), 64'(w35(2, 1, 1, 27)));
        chk("hold_end_d32", 64'(d32), 64'(w32(0, 3)));
        chk("hold_end_temp", 64'(temp_disp), 64'd27);

        do_reset();
        f0 = frames;
        kb[4] = 1'b1; cyc(10);
        kb[1] = 1'b1;
        wait_frame(f0 + 1);
        cyc(25);
        chk("pend_frames", 64'(frames - f0), 64'd1);
        chk("pend_temp", 64'(temp_disp), 64'd27);
        #3 rst = 1'b0;
        #1;
        chk("rst_hold_d35", 64'(d35), 64'd0);
        chk("rst_hold_d32", 64'(d32), 64'd0);
        chk("rst_hold_stb", 64'(frame_stb), 64'd0);
        chk("rst_hold_temp", 64'(temp_disp), 64'd26);
        kb = '0;
        cyc(5);
        rst = 1'b1;
        cyc(150);
        chk("rst_rel_frames", 64'(frames - f0), 64'd1);
        chk("rst_rel_d35", 64'(d35), 64'd0);
        chk("rst_rel_d32", 64'(d32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
